// File: rtl/fx2_cmd_parser.sv
// fx2_cmd_parser: host command frame parser for the timetag register file.
// Frame on the wire: MAGIC, mode (00 = read, 01 = write), address, then
// VALUE_BYTES value bytes, least significant byte first. A write frame ends
// in a single-cycle reg_wr strobe. A read frame ends in a single-cycle reg_rd
// strobe followed by a reply of MAGIC, address and the read value, LSB first.
//
// Handshakes: a byte moves on either stream in exactly the cycle where its
// valid and ready are both high at the rising clock edge. The producer holds
// data stable while valid is high and ready is low. cmd_ready and reply_valid
// are decoded from the state register only, so they never depend
// combinationally on the other side's valid/ready.
module fx2_cmd_parser #(
  parameter int         VALUE_BYTES = 1,
  parameter logic [7:0] MAGIC       = 8'hAA,
  parameter int         TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [7:0]               reg_addr,
  output logic [8*VALUE_BYTES-1:0] reg_wdata,
  output logic                     reg_wr,
  output logic                     reg_rd,
  input  logic [8*VALUE_BYTES-1:0] reg_rdata,
  output logic [7:0]               reply_data,
  output logic                     reply_valid,
  input  logic                     reply_ready,
  output logic                     busy,
  output logic [7:0]               err_count
);

  localparam int RW  = 8 * VALUE_BYTES;
  // Reply length: MAGIC, address, value bytes.
  localparam int RB  = VALUE_BYTES + 2;
  localparam int SRW = 8 * RB;
  localparam int IW  = (VALUE_BYTES > 1) ? $clog2(VALUE_BYTES) : 1;
  localparam int CW  = $clog2(RB);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(VALUE_BYTES - 1);
  localparam logic [CW-1:0] REP_LAST   = CW'(RB - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_MODE,
    S_ADDR,
    S_VALUE,
    S_EXEC_WR,
    S_EXEC_RD,
    S_RD_CAP,
    S_REPLY
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [RW-1:0]   reg_wdata_q, reg_wdata_d;
  logic [SRW-1:0]  rep_sr_q, rep_sr_d;
  logic [CW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [7:0]      err_q, err_d;

  logic cmd_acc;
  logic rep_acc;
  logic in_frame;
  logic err_inc;

  // Output decode straight from the state register and data flops.
  assign cmd_ready   = (state_q == S_HUNT) || (state_q == S_MODE) ||
                       (state_q == S_ADDR) || (state_q == S_VALUE);
  assign reg_wr      = (state_q == S_EXEC_WR);
  assign reg_rd      = (state_q == S_EXEC_RD);
  assign reply_valid = (state_q == S_REPLY);
  assign reply_data  = rep_sr_q[7:0];
  assign busy        = (state_q != S_HUNT);
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign err_count   = err_q;

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign rep_acc  = reply_valid && reply_ready;
  // Only the mid-frame states run the stall timer.
  assign in_frame = (state_q == S_MODE) || (state_q == S_ADDR) ||
                    (state_q == S_VALUE);

  // Next-state, datapath, stall timer and error counter.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rep_sr_d    = rep_sr_q;
    rep_cnt_d   = rep_cnt_q;
    err_d       = err_q;
    err_inc     = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (cmd_acc) begin
          if (cmd_data == MAGIC) state_d = S_MODE;
          else                   err_inc = 1'b1;
        end
      end
      S_MODE: begin
        // A second MAGIC here is a bad mode byte, not a resync.
        if (cmd_acc) begin
          if (cmd_data == 8'h00) begin
            is_wr_d = 1'b0;
            state_d = S_ADDR;
          end else if (cmd_data == 8'h01) begin
            is_wr_d = 1'b1;
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_ADDR: begin
        // Reads also carry value bytes (ignored) so every frame has one length.
        if (cmd_acc) begin
          reg_addr_d = cmd_data;
          idx_d      = '0;
          state_d    = S_VALUE;
        end
      end
      S_VALUE: begin
        if (cmd_acc) begin
          if (is_wr_q) reg_wdata_d[8*idx_q +: 8] = cmd_data;
          if (idx_q == IDX_LAST) state_d = is_wr_q ? S_EXEC_WR : S_EXEC_RD;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_EXEC_WR: state_d = S_HUNT;
      S_EXEC_RD: state_d = S_RD_CAP;
      S_RD_CAP: begin
        // reg_rdata is valid in the cycle after the reg_rd strobe.
        rep_sr_d  = {reg_rdata, reg_addr_q, MAGIC};
        rep_cnt_d = '0;
        state_d   = S_REPLY;
      end
      S_REPLY: begin
        // The shift register only moves on a handshake, so reply_data holds
        // steady under back-pressure.
        if (rep_acc) begin
          if (rep_cnt_q == REP_LAST) begin
            state_d = S_HUNT;
          end else begin
            rep_sr_d  = {8'h00, rep_sr_q[SRW-1:8]};
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Stalled frame abort: TIMEOUT consecutive cycles with no accepted byte.
    if (in_frame) begin
      if (cmd_acc) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        state_d = S_HUNT;
        err_inc = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end

    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // Parser state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HUNT;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      timer_q     <= '0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= '0;
      rep_sr_q    <= '0;
      rep_cnt_q   <= '0;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rep_sr_q    <= rep_sr_d;
      rep_cnt_q   <= rep_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
